// File: rtl/spect_frame_packer.sv
// spect_frame_packer: packs a 32-bit sample stream into 128-bit words, one header word per frame
// Ports: clk; rst (async, active high); din/din_valid/sync sample stream (sync marks lane 0 of a frame);
//   frame_len samples per frame (bits[1:0] ignored); fifo_full drops whole frames at frame start;
//   dout/dout_valid packed words; seq_num, err_cnt, drop_cnt status; frame_active while packing.
// Optional: define FRAME_TRAILER_EN to follow each completed frame with a {err_cnt, frame_len, ~MAGIC} trailer.
module spect_frame_packer #(
    parameter logic [31:0] MAGIC = 32'hF4B0CAFE,
    parameter int          ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      din,
    input  logic             din_valid,
    input  logic             sync,
    input  logic [31:0]      frame_len,
    input  logic             fifo_full,
    output logic [127:0]     dout,
    output logic             dout_valid,
    output logic [31:0]      seq_num,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] drop_cnt,
    output logic             frame_active
);
    typedef enum logic {IDLE, PACK} state_t;
    state_t       state;
    logic [63:0]  ts;
    logic [95:0]  lanes;
    logic [1:0]   lane;
    logic [29:0]  words;
    logic         valid_sync, start, drop, take, word_done, last_word;
    logic [127:0] hdr;
`ifdef FRAME_TRAILER_EN
    logic         trl_due, hdr_pend;
    logic [127:0] hdr_word;
    logic [31:0]  len_lat;
`endif
    // A sync with a zero word count is ignored everywhere, so it never counts as a start, drop or abort.
    always_comb begin
        valid_sync = din_valid && sync && (frame_len & ~32'd3) != 32'd0;
        start      = valid_sync && !fifo_full;
        drop       = valid_sync && fifo_full;
        take       = state == PACK && din_valid && !valid_sync;
        word_done  = take && lane == 2'd3;
        last_word  = word_done && words == 30'd1;
        hdr        = {ts, seq_num + 32'd1, MAGIC};
    end
    // Samples shift in from the top so that after three shifts lanes holds {s2, s1, s0}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ts           <= '0;
            lanes        <= '0;
            lane         <= '0;
            words        <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            seq_num      <= '0;
            err_cnt      <= '0;
            drop_cnt     <= '0;
            frame_active <= 1'b0;
`ifdef FRAME_TRAILER_EN
            trl_due      <= 1'b0;
            hdr_pend     <= 1'b0;
            hdr_word     <= '0;
            len_lat      <= '0;
`endif
        end else begin
            ts         <= ts + 64'd1;
            dout_valid <= 1'b0;
            if (valid_sync && state == PACK && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + ERR_W'(1);
            if (start) begin
                state        <= PACK;
                frame_active <= 1'b1;
                seq_num      <= seq_num + 32'd1;
                lanes        <= {din, lanes[95:32]};
                lane         <= 2'd1;
                words        <= frame_len[31:2];
                dout         <= hdr;
                dout_valid   <= 1'b1;
`ifdef FRAME_TRAILER_EN
                len_lat      <= frame_len;
`endif
            end else if (drop) begin
                state        <= IDLE;
                frame_active <= 1'b0;
            end else if (take) begin
                lanes <= {din, lanes[95:32]};
                lane  <= lane + 2'd1;
                if (word_done) begin
                    dout       <= {din, lanes};
                    dout_valid <= 1'b1;
                    words      <= words - 30'd1;
                end
                if (last_word) begin
                    state        <= IDLE;
                    frame_active <= 1'b0;
                end
            end
`ifdef FRAME_TRAILER_EN
            // The trailer owns the output slot after a last word; a header due then waits one cycle.
            trl_due  <= last_word;
            hdr_pend <= 1'b0;
            if (trl_due) begin
                dout       <= {32'(err_cnt), 32'h0, len_lat, ~MAGIC};
                dout_valid <= 1'b1;
                hdr_pend   <= start;
                hdr_word   <= hdr;
            end else if (hdr_pend && !start) begin
                dout       <= hdr_word;
                dout_valid <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_spect_frame_packer.sv
// tb_spect_frame_packer: directed self-checking bench for spect_frame_packer
module tb_spect_frame_packer;
    localparam logic [31:0] MAGIC = 32'hF4B0CAFE;
    logic         clk = 1'b0, rst = 1'b1, din_valid = 1'b0, sync = 1'b0, fifo_full = 1'b0;
    logic [31:0]  din = '0, frame_len = '0;
    logic [127:0] dout;
    logic         dout_valid, frame_active;
    logic [31:0]  seq_num;
    logic [15:0]  err_cnt, drop_cnt;
    int           checks = 0, errors = 0, nvalid = 0;
    logic [63:0]  tsm = '0, ts_at = '0, hdr_ts = '0;

    spect_frame_packer dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .frame_len(frame_len), .fifo_full(fifo_full), .dout(dout), .dout_valid(dout_valid),
        .seq_num(seq_num), .err_cnt(err_cnt), .drop_cnt(drop_cnt), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ts_at is the timestamp value the DUT sees at the edge just taken.
    task automatic step(input logic v, input logic s, input logic [31:0] d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
        ts_at = tsm;
        tsm++;
        if (dout_valid) nvalid++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        sync = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tsm = '0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_dout", dout, 128'd0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_seq", seq_num, 32'd0);
        chk("rst_err", err_cnt, 16'd0);
        chk("rst_drop", drop_cnt, 16'd0);
        chk("rst_active", frame_active, 1'b0);
        rst = 1'b0;
        tsm = '0;
        // 1: basic frame of 8 samples
        frame_len = 8;
        nvalid = 0;
        step(1, 1, 32'd1);
        hdr_ts = ts_at;
        chk("t1_hdr", dout, {hdr_ts, 32'd1, MAGIC});
        chk("t1_hdr_valid", dout_valid, 1'b1);
        chk("t1_seq", seq_num, 32'd1);
        chk("t1_active", frame_active, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            step(1, 0, 32'(i));
            if (i == 4) chk("t1_word0", dout, {32'd4, 32'd3, 32'd2, 32'd1});
            if (i == 8) chk("t1_word1", dout, {32'd8, 32'd7, 32'd6, 32'd5});
        end
        chk("t1_active_end", frame_active, 1'b0);
        chk("t1_nvalid", nvalid, 3);
        step(0, 0, 32'd0);
        chk("t1_idle_valid", dout_valid, 1'b0);
        // 2: frame dropped on fifo_full
        do_reset();
        nvalid = 0;
        fifo_full = 1'b1;
        step(1, 1, 32'd9);
        chk("t2_drop", drop_cnt, 16'd1);
        chk("t2_seq", seq_num, 32'd0);
        chk("t2_active", frame_active, 1'b0);
        fifo_full = 1'b0;
        for (int i = 10; i <= 13; i++) step(1, 0, 32'(i));
        chk("t2_nvalid", nvalid, 0);
        // 3: sync mid-frame aborts, new frame packs fully; fifo_full mid-frame ignored
        frame_len = 16;
        step(1, 1, 32'd100);
        chk("t3_hdr1", dout, {ts_at, 32'd1, MAGIC});
        for (int i = 101; i <= 105; i++) begin
            step(1, 0, 32'(i));
            if (i == 103) chk("t3_word_a", dout, {32'd103, 32'd102, 32'd101, 32'd100});
        end
        nvalid = 0;
        step(1, 1, 32'd200);
        chk("t3_hdr2", dout, {ts_at, 32'd2, MAGIC});
        chk("t3_err", err_cnt, 16'd1);
        chk("t3_seq", seq_num, 32'd2);
        for (int i = 201; i <= 215; i++) begin
            fifo_full = (i <= 205);
            step(1, 0, 32'(i));
            if (i == 207) chk("t3_word_c", dout, {32'd207, 32'd206, 32'd205, 32'd204});
            if (i == 215) chk("t3_word_e", dout, {32'd215, 32'd214, 32'd213, 32'd212});
        end
        fifo_full = 1'b0;
        chk("t3_nvalid", nvalid, 5);
        chk("t3_active_end", frame_active, 1'b0);
        chk("t3_drop_keep", drop_cnt, 16'd1);
        // 4: gapped input, frame_len change mid-frame has no effect
        frame_len = 4;
        nvalid = 0;
        step(1, 1, 32'h10);
        frame_len = 8;
        step(0, 0, 32'd0);
        step(0, 0, 32'd0);
        step(1, 0, 32'h11);
        step(0, 0, 32'd0);
        step(0, 0, 32'd0);
        step(1, 0, 32'h12);
        chk("t4_active_mid", frame_active, 1'b1);
        step(0, 0, 32'd0);
        step(0, 0, 32'd0);
        step(1, 0, 32'h13);
        chk("t4_word", dout, {32'h13, 32'h12, 32'h11, 32'h10});
        chk("t4_word_valid", dout_valid, 1'b1);
        chk("t4_active_end", frame_active, 1'b0);
        step(0, 0, 32'd0);
        chk("t4_after_valid", dout_valid, 1'b0);
        chk("t4_nvalid", nvalid, 2);
        // frame_len below 4: sync ignored, even with fifo_full
        frame_len = 3;
        fifo_full = 1'b1;
        step(1, 1, 32'd5);
        chk("t4b_valid", dout_valid, 1'b0);
        chk("t4b_active", frame_active, 1'b0);
        chk("t4b_drop", drop_cnt, 16'd1);
        chk("t4b_seq", seq_num, 32'd3);
        fifo_full = 1'b0;
        // 5: async reset mid-frame
        frame_len = 8;
        step(1, 1, 32'h20);
        step(1, 0, 32'h21);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_dout", dout, 128'd0);
        chk("t5_valid", dout_valid, 1'b0);
        chk("t5_seq", seq_num, 32'd0);
        chk("t5_err", err_cnt, 16'd0);
        chk("t5_drop", drop_cnt, 16'd0);
        chk("t5_active", frame_active, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tsm = '0;
        nvalid = 0;
        for (int i = 0; i < 4; i++) step(1, 0, 32'(i + 34));
        chk("t5_nvalid", nvalid, 0);
`ifdef FRAME_TRAILER_EN
        // 6: data, trailer, held header in consecutive cycles
        frame_len = 4;
        step(1, 1, 32'd1);
        step(1, 0, 32'd2);
        step(1, 0, 32'd3);
        step(1, 0, 32'd4);
        chk("t6_data", dout, {32'd4, 32'd3, 32'd2, 32'd1});
        step(1, 1, 32'd5);
        hdr_ts = ts_at;
        chk("t6_trailer", dout, {32'd0, 32'd0, 32'd4, ~MAGIC});
        chk("t6_trailer_valid", dout_valid, 1'b1);
        step(1, 0, 32'd6);
        chk("t6_hdr", dout, {hdr_ts, 32'd2, MAGIC});
        chk("t6_hdr_valid", dout_valid, 1'b1);
        step(1, 0, 32'd7);
        step(1, 0, 32'd8);
        chk("t6_data2", dout, {32'd8, 32'd7, 32'd6, 32'd5});
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
